// File: rtl/data_restorer.sv
// Receive-side descrambler: XORs each scrambled word with the LFSR keystream
// regenerated from the shared seed, one bit per cycle, LSB first, over a req/ack handshake.
`timescale 1ns/1ps

module data_restorer #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    LFSR_WIDTH = 24,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS  = 24'hE10000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic [LFSR_WIDTH-1:0] seed,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ack,
  output logic                  busy,
  output logic                  abort
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] work_q, work_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic                  abort_q, abort_d;
  logic [DATA_WIDTH:0]   work_ext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      lfsr_q     <= '0;
      cnt_q      <= '0;
      din_q      <= '0;
      work_q     <= '0;
      data_out_q <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      din_q      <= din_d;
      work_q     <= work_d;
      data_out_q <= data_out_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      abort_q    <= abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    din_d      = din_q;
    work_d     = work_q;
    data_out_d = data_out_q;
    ack_d      = ack_q;
    busy_d     = busy_q;
    abort_d    = 1'b0;
    // New result bit enters at the top so bit k lands in position k after the last step.
    work_ext   = {din_q[0] ^ lfsr_q[0], work_q};

    case (state_q)
      IDLE: begin
        if (req) begin
          lfsr_d  = seed;
          din_d   = data_in;
          work_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (!req) begin
          busy_d  = 1'b0;
          abort_d = 1'b1;
          state_d = IDLE;
        end else begin
          work_d = work_ext[DATA_WIDTH:1];
          din_d  = din_q >> 1;
          lfsr_d = {lfsr_q[LFSR_WIDTH-2:0], ^(lfsr_q & LFSR_TAPS)};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            data_out_d = work_ext[DATA_WIDTH:1];
            ack_d      = 1'b1;
            busy_d     = 1'b0;
            state_d    = DONE;
          end
        end
      end

      DONE: begin
        if (!req) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign data_out = data_out_q;
  assign ack      = ack_q;
  assign busy     = busy_q;
  assign abort    = abort_q;

endmodule

// File: tb/tb_data_restorer.sv
// Self-checking bench for data_restorer: directed keystream vectors, abort and reset
// cases, then random scramble/restore round trips against a word-level keystream model.
`timescale 1ns/1ps

module tb_data_restorer;

  localparam int            DW   = 8;
  localparam int            LW   = 24;
  localparam logic [LW-1:0] TAPS = 24'hE10000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req = 1'b0;
  logic [LW-1:0] seed = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          ack;
  logic          busy;
  logic          abort;

  int checkCount = 0;
  int passCount  = 0;

  data_restorer #(
    .DATA_WIDTH(DW),
    .LFSR_WIDTH(LW),
    .LFSR_TAPS (TAPS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .seed    (seed),
    .data_in (data_in),
    .data_out(data_out),
    .ack     (ack),
    .busy    (busy),
    .abort   (abort)
  );

  always #5 clk = ~clk;

  // Whole-word keystream: bit k is the low state bit before the k-th LFSR step.
  function automatic logic [DW-1:0] keystream(input logic [LW-1:0] s);
    int unsigned   state;
    int unsigned   fb;
    logic [DW-1:0] k;
    state = 32'(s);
    k     = '0;
    for (int i = 0; i < DW; i++) begin
      k[i]  = state[0];
      fb    = 32'($countones(LW'(state) & TAPS) % 2);
      state = ((state * 2) + fb) % (32'd1 << LW);
    end
    return k;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [LW-1:0] s, input logic [DW-1:0] d);
    req     = 1'b1;
    seed    = s;
    data_in = d;
  endtask

  // Full handshake from a negedge in IDLE (req low at the previous edge) back to IDLE.
  task automatic runTxn(input logic [LW-1:0] s, input logic [DW-1:0] d,
                        input logic [DW-1:0] expected, input string tag);
    int cycles;
    int busyCount;
    applyStimulus(s, d);
    @(posedge clk);
    #1;
    seed      = LW'($urandom);
    data_in   = DW'($urandom);
    cycles    = 0;
    busyCount = 0;
    while (cycles < 20) begin
      @(negedge clk);
      if (ack) break;
      if (busy) busyCount++;
      cycles++;
    end
    checkOutput({tag, " ack"}, 32'(ack), 32'd1);
    checkOutput({tag, " data_out"}, 32'(data_out), 32'(expected));
    checkOutput({tag, " latency"}, 32'(cycles), 32'(DW));
    checkOutput({tag, " busy_cycles"}, 32'(busyCount), 32'(DW));
    checkOutput({tag, " busy_in_done"}, 32'(busy), 32'd0);
    req = 1'b0;
    @(negedge clk);
    checkOutput({tag, " ack_drop"}, 32'(ack), 32'd0);
    checkOutput({tag, " data_hold"}, 32'(data_out), 32'(expected));
  endtask

  initial begin
    logic [LW-1:0] s;
    logic [DW-1:0] orig;

    #1;
    checkOutput("reset data_out", 32'(data_out), 32'd0);
    checkOutput("reset ack", 32'(ack), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset abort", 32'(abort), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    runTxn(24'h000001, 8'hA5, 8'hA4, "seed1");
    runTxn(24'h000000, 8'h3C, 8'h3C, "seed0");
    runTxn(24'h810001, 8'h00, 8'hC1, "feedback");

    // Drop req after three shift edges.
    applyStimulus(24'h123456, 8'h5A);
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("abort busy_before", 32'(busy), 32'd1);
    req = 1'b0;
    @(negedge clk);
    checkOutput("abort pulse", 32'(abort), 32'd1);
    checkOutput("abort ack", 32'(ack), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort data_out", 32'(data_out), 32'hC1);
    @(negedge clk);
    checkOutput("abort pulse_end", 32'(abort), 32'd0);
    runTxn(24'h000001, 8'hFF, 8'hFE, "after_abort");

    // Reset in the middle of SHIFT.
    applyStimulus(24'hABCDEF, 8'h77);
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_shift data_out", 32'(data_out), 32'd0);
    checkOutput("rst_shift ack", 32'(ack), 32'd0);
    checkOutput("rst_shift busy", 32'(busy), 32'd0);
    checkOutput("rst_shift abort", 32'(abort), 32'd0);
    req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    runTxn(24'h810001, 8'hFF, 8'h3E, "after_rst_shift");

    // Reset while presenting a result in DONE.
    applyStimulus(24'h000001, 8'h10);
    @(posedge clk);
    repeat (DW) @(posedge clk);
    @(negedge clk);
    checkOutput("pre_rst_done ack", 32'(ack), 32'd1);
    checkOutput("pre_rst_done data_out", 32'(data_out), 32'h11);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_done data_out", 32'(data_out), 32'd0);
    checkOutput("rst_done ack", 32'(ack), 32'd0);
    checkOutput("rst_done busy", 32'(busy), 32'd0);
    checkOutput("rst_done abort", 32'(abort), 32'd0);
    req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    runTxn(24'h000000, 8'h96, 8'h96, "after_rst_done");

    // Scramble random words with the model, then restore them with the DUT.
    for (int i = 0; i < 1000; i++) begin
      s    = LW'($urandom);
      orig = DW'($urandom);
      runTxn(s, orig ^ keystream(s), orig, "roundtrip");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
